// File: rtl/screen_streamer_if.sv
// Pixel stream bus between screen_streamer and a display/serial sink.
interface screen_streamer_if #(
  parameter int unsigned COORD_W = 8
) ();
  logic [23:0]        out_pixel;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic               out_valid;
  logic               out_ready;
  logic               out_sof;
  logic               out_eol;
  logic               out_last;

  modport master (
    output out_pixel, out_x, out_y, out_valid, out_sof, out_eol, out_last,
    input  out_ready
  );

  modport slave (
    input  out_pixel, out_x, out_y, out_valid, out_sof, out_eol, out_last,
    output out_ready
  );
endinterface

// File: rtl/screen_streamer.sv
// Snapshots the game screen on request and streams it pixel by pixel in raster
// order (row 0 first, x fastest) with coordinates and framing flags.
module screen_streamer #(
  parameter int unsigned SCR_W   = 30,
  parameter int unsigned SCR_H   = 30,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SCR_W*SCR_H*24-1:0] screen,
  input  logic                     frame_req,
  screen_streamer_if.master        bus,
  output logic                     busy,
  output logic                     frame_done,
  output logic [FCNT_W-1:0]        frame_count
);

  localparam int unsigned FRAME_BITS = SCR_W * SCR_H * 24;
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(SCR_W - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(SCR_H - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t               state, stateNext;
  logic [COORD_W-1:0]   x, y, xNext, yNext;
  logic                 pending, pendingNext;
  logic [FCNT_W-1:0]    countNext;
  logic                 capture;
  logic                 accept;
  logic                 streaming;
  logic                 atEol, atLast;
  logic [IDX_W-1:0]     pixBase;
  logic [FRAME_BITS-1:0] snapshot;

  assign streaming = (state == STREAM);
  assign accept    = streaming && bus.out_ready;
  assign atEol     = (x == LAST_X);
  assign atLast    = atEol && (y == LAST_Y);

  // Frame buffer is column-major: pixel (x,y) lives at flat index x*SCR_H + y.
  assign pixBase = IDX_W'((32'(x) * 32'(SCR_H) + 32'(y)) * 32'd24);

  // Flags are gated so nothing framing-related is visible outside STREAM.
  assign bus.out_valid = streaming;
  assign bus.out_pixel = snapshot[pixBase +: 24];
  assign bus.out_x     = x;
  assign bus.out_y     = y;
  assign bus.out_sof   = streaming && (x == '0) && (y == '0);
  assign bus.out_eol   = streaming && atEol;
  assign bus.out_last  = streaming && atLast;
  assign busy          = (state != IDLE);
  assign frame_done    = (state == DONE);

  // Next-state, coordinate, pending and counter logic.
  always_comb begin
    stateNext   = state;
    xNext       = x;
    yNext       = y;
    pendingNext = pending;
    countNext   = frame_count;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_req) begin
          capture   = 1'b1;
          xNext     = '0;
          yNext     = '0;
          stateNext = STREAM;
        end
      end
      STREAM: begin
        if (frame_req) pendingNext = 1'b1;
        if (accept) begin
          if (atLast) begin
            stateNext = DONE;
          end else if (atEol) begin
            xNext = '0;
            yNext = y + COORD_W'(1);
          end else begin
            xNext = x + COORD_W'(1);
          end
        end
      end
      DONE: begin
        countNext   = frame_count + FCNT_W'(1);
        pendingNext = 1'b0;
        if (pending || frame_req) begin
          capture   = 1'b1;
          xNext     = '0;
          yNext     = '0;
          stateNext = STREAM;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pending     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= stateNext;
      x           <= xNext;
      y           <= yNext;
      pending     <= pendingNext;
      frame_count <= countNext;
    end
  end

  // Snapshot content is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) snapshot <= screen;
  end

endmodule
